// File: rtl/spi_la_pkg.sv
// Shared constants for the SPI logic-analyzer capture path: state encoding,
// byte width and the post-capture frame counter ceiling.
package spi_la_pkg;

  localparam int BYTE_W = 8;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam logic [BYTE_W-1:0] POST_FRAMES_MAX = 8'd255;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    ARMED   = ST_ARMED,
    CAPTURE = ST_CAPTURE,
    DONE    = ST_DONE
  } cap_state_e;

endpackage

// File: rtl/spi_capture_buf.sv
// DEPTH x 8 simple dual-port capture buffer: synchronous write, registered read.
// A read that hits the address being written in the same cycle returns the new byte.
module spi_capture_buf
  import spi_la_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [BYTE_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [BYTE_W-1:0] rdata_o
);

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [BYTE_W-1:0] rdata_q;

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/spi_capture_ctrl.sv
// Arm / trigger / capture / readout sequencer for one SPI byte decoder.
// Optional idle timeout in CAPTURE is built when SPI_CAPTURE_TIMEOUT_EN is defined.
module spi_capture_ctrl
  import spi_la_pkg::*;
#(
  parameter int DEPTH = 16,
`ifdef SPI_CAPTURE_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES = 65535,
`endif
  parameter int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              abort,
  input  logic [BYTE_W-1:0] trig_byte,
  input  logic [BYTE_W-1:0] trig_mask,
  input  logic [AW:0]       capture_len,
  input  logic [BYTE_W-1:0] dec_data,
  input  logic              dec_valid,
  input  logic              dec_detected,
  output logic              dec_detect_only,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  input  logic              rd_en,
  output logic [BYTE_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_empty,
  output logic [BYTE_W-1:0] post_frames,
  output cap_state_e        dbg_state
);

  localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  cap_state_e        state_q, state_d;
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [AW:0]       len_q, len_d;
  logic [BYTE_W-1:0] post_q, post_d;
  logic              wen_q, wen_d;
  logic [AW-1:0]     waddr_q, waddr_d;
  logic [BYTE_W-1:0] wdata_q, wdata_d;
  logic              rd_valid_q, rd_valid_d;

  logic [AW:0] wr_next;
  logic [AW:0] len_eff;
  logic        trig_hit;
  logic        arm_accept;
  logic        rd_accept;
  logic        rd_empty_w;

  assign wr_next    = wr_ptr_q + PTR_ONE;
  assign len_eff    = ((capture_len == '0) || (capture_len > DEPTH_L)) ? DEPTH_L : capture_len;
  assign trig_hit   = ((dec_data ^ trig_byte) & trig_mask) == '0;
  assign arm_accept = arm && !abort && ((state_q == IDLE) || (state_q == DONE));
  assign rd_empty_w = (state_q != DONE) || (rd_ptr_q == wr_ptr_q);
  assign rd_accept  = rd_en && !rd_empty_w && !abort && !arm_accept;

`ifdef SPI_CAPTURE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_cnt_q;
  logic          tmo_flag_q;
  logic          tmo_fire;

  // A final byte landing on the limit cycle completes normally, not as a timeout.
  assign tmo_fire = (state_q == CAPTURE) && (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) &&
                    !(dec_valid && (wr_next == len_q));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q  <= '0;
      tmo_flag_q <= 1'b0;
    end else begin
      if (dec_detected || ((state_q != CAPTURE) && (state_d == CAPTURE))) tmo_cnt_q <= '0;
      else if (state_q == CAPTURE) tmo_cnt_q <= tmo_cnt_q + TW'(1);

      if (abort || arm_accept) tmo_flag_q <= 1'b0;
      else if (tmo_fire) tmo_flag_q <= 1'b1;
    end
  end

  assign timeout = tmo_flag_q;
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_accept ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    len_d      = len_q;
    post_d     = post_q;
    wen_d      = 1'b0;
    waddr_d    = wr_ptr_q[AW-1:0];
    wdata_d    = dec_data;
    rd_valid_d = rd_accept;

    if (abort) begin
      state_d = IDLE;
    end else if (arm_accept) begin
      state_d  = ARMED;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      post_d   = '0;
      len_d    = len_eff;
    end else begin
      unique case (state_q)
        ARMED: begin
          if (dec_valid && trig_hit) begin
            wen_d    = 1'b1;
            waddr_d  = '0;
            wr_ptr_d = PTR_ONE;
            state_d  = (len_q == PTR_ONE) ? DONE : CAPTURE;
          end
        end
        CAPTURE: begin
          if (dec_valid) begin
            wen_d    = 1'b1;
            wr_ptr_d = wr_next;
            if (wr_next == len_q) state_d = DONE;
          end
`ifdef SPI_CAPTURE_TIMEOUT_EN
          if (tmo_fire) state_d = DONE;
`endif
        end
        DONE: begin
          if (dec_detected && (post_q != POST_FRAMES_MAX)) post_d = post_q + 8'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      len_q      <= '0;
      post_q     <= '0;
      wen_q      <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      len_q      <= len_d;
      post_q     <= post_d;
      wen_q      <= wen_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  spi_capture_buf #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .we_i    (wen_q),
    .waddr_i (waddr_q),
    .wdata_i (wdata_q),
    .re_i    (rd_accept),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (rd_data)
  );

  assign busy            = (state_q == ARMED) || (state_q == CAPTURE);
  assign dec_detect_only = !busy;
  assign done            = (state_q == DONE);
  assign rd_valid        = rd_valid_q;
  assign rd_empty        = rd_empty_w;
  assign post_frames     = post_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_spi_capture_ctrl.sv
// Self-checking bench for spi_capture_ctrl against a transaction-level capture model.
// Timeout scenarios are included when SPI_CAPTURE_TIMEOUT_EN is defined.
module tb_spi_capture_ctrl;
  import spi_la_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk, rst, arm, abort, dec_valid, dec_detected, rd_en;
  logic [7:0]    trig_byte, trig_mask, dec_data;
  logic [AW:0]   capture_len;
  logic          dec_detect_only, busy, done, timeout, rd_valid, rd_empty;
  logic [7:0]    rd_data, post_frames;
  cap_state_e    dbg_state;

  spi_capture_ctrl #(
    .DEPTH (DEPTH),
`ifdef SPI_CAPTURE_TIMEOUT_EN
    .TIMEOUT_CYCLES (100),
`endif
    .AW (AW)
  ) dut (
    .clk (clk), .rst (rst), .arm (arm), .abort (abort),
    .trig_byte (trig_byte), .trig_mask (trig_mask), .capture_len (capture_len),
    .dec_data (dec_data), .dec_valid (dec_valid), .dec_detected (dec_detected),
    .dec_detect_only (dec_detect_only), .busy (busy), .done (done), .timeout (timeout),
    .rd_en (rd_en), .rd_data (rd_data), .rd_valid (rd_valid), .rd_empty (rd_empty),
    .post_frames (post_frames), .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad   = 0;

  // Reference model: phase 0 idle, 1 waiting for trigger, 2 filling, 3 full
  int         m_phase;
  logic [7:0] m_tb, m_tm;
  int         m_len, m_cap, m_post;
  bit         m_tmo;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_status(input string tag);
    chk({tag, ".busy"}, busy, (m_phase == 1 || m_phase == 2));
    chk({tag, ".done"}, done, (m_phase == 3));
    chk({tag, ".detect_only"}, dec_detect_only, !(m_phase == 1 || m_phase == 2));
    chk({tag, ".rd_empty"}, rd_empty, (m_phase != 3) || (exp_q.size() == 0));
    chk({tag, ".post_frames"}, post_frames, m_post);
    chk({tag, ".timeout"}, timeout, m_tmo);
    chk({tag, ".state"}, dbg_state, m_phase);
  endtask

  task automatic model_reset();
    m_phase = 0; m_post = 0; m_tmo = 0; m_cap = 0; m_len = DEPTH;
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Driver tasks: each starts and ends at a falling edge and spans one cycle.
  task automatic do_arm(input logic [7:0] t, input logic [7:0] m, input logic [AW:0] len);
    trig_byte = t; trig_mask = m; capture_len = len; arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    m_tb = t; m_tm = m;
    if (m_phase == 0 || m_phase == 3) begin
      m_phase = 1;
      m_len   = (len == 0 || len > DEPTH) ? DEPTH : int'(len);
      m_cap   = 0; m_post = 0; m_tmo = 0;
      exp_q.delete();
    end
  endtask

  task automatic model_store(input logic [7:0] d);
    exp_q.push_back(d);
    m_cap++;
    m_phase = (m_cap == m_len) ? 3 : 2;
  endtask

  task automatic send_byte(input logic [7:0] d);
    dec_data = d; dec_valid = 1'b1;
    @(negedge clk);
    dec_valid = 1'b0;
    if (m_phase == 1 && (((d ^ m_tb) & m_tm) == 8'h00)) model_store(d);
    else if (m_phase == 2) model_store(d);
  endtask

  task automatic pulse_detect();
    dec_detected = 1'b1;
    @(negedge clk);
    dec_detected = 1'b0;
    if (m_phase == 3 && m_post < 255) m_post++;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    m_phase = 0; m_tmo = 0;
  endtask

  task automatic do_read(input string tag);
    logic [7:0] e;
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    if (m_phase == 3 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, ".rd_valid"}, rd_valid, 1);
      chk({tag, ".rd_data"}, rd_data, e);
    end else begin
      chk({tag, ".rd_valid_idle"}, rd_valid, 0);
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = exp_q.size();
    for (int i = 0; i <= n; i++) do_read(tag);
  endtask

  initial begin
    arm = 0; abort = 0; dec_valid = 0; dec_detected = 0; rd_en = 0;
    trig_byte = 0; trig_mask = 0; dec_data = 0; capture_len = 0;
    rst = 1'b0;
    @(negedge clk);
    do_reset();

    // Reset state
    check_status("reset");
    chk("reset.rd_data", rd_data, 0);
    chk("reset.rd_valid", rd_valid, 0);

    // Exact trigger, length 4, with a leading non-matching byte
    do_arm(8'hA5, 8'hFF, 5'd4);
    check_status("t1.armed");
    send_byte(8'h3C);
    check_status("t1.discard");
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h02);
    check_status("t1.filling");
    send_byte(8'h03);
    check_status("t1.full");
    send_byte(8'hEE);
    drain("t1.read");
    check_status("t1.drained");

    // Masked trigger on the upper nibble
    do_arm(8'hA0, 8'hF0, 5'd3);
    send_byte(8'h5A);
    check_status("t2.nomatch");
    send_byte(8'hAF);
    check_status("t2.trig");
    send_byte(8'h11);
    check_status("t2.mid");
    send_byte(8'h22);
    check_status("t2.full");

    // Frame counter saturation and clear on re-arm
    for (int i = 0; i < 300; i++) pulse_detect();
    check_status("t3.sat");
    chk("t3.post255", post_frames, 255);
    drain("t3.read");
    do_arm(8'h00, 8'h00, 5'd2);
    check_status("t3.rearm");

    // Abort mid-capture
    do_abort();
    do_arm(8'h5A, 8'hFF, 5'd8);
    send_byte(8'h5A);
    send_byte(8'h01);
    check_status("t4.two");
    do_abort();
    check_status("t4.aborted");
    do_read("t4.read");

    // Length 0 means full depth; the 17th byte is dropped
    do_arm(8'h00, 8'h00, 5'd0);
    for (int i = 0; i < DEPTH + 1; i++) send_byte(8'($urandom_range(0, 255)));
    check_status("t5.full");
    drain("t5.read");
    check_status("t5.drained");

    // Length 1: trigger byte alone, read back immediately
    do_arm(8'h77, 8'hFF, 5'd1);
    send_byte(8'h77);
    check_status("t6.len1");
    drain("t6.read");

    // Randomized sessions, including ignored arms and lengths above depth
    for (int it = 0; it < 24; it++) begin
      logic [7:0] t, m, d;
      int mk;
      t  = 8'($urandom_range(0, 255));
      mk = $urandom_range(0, 3);
      m  = (mk == 0) ? 8'h00 : (mk == 1) ? 8'hFF : 8'($urandom_range(0, 255));
      do_arm(t, m, (AW + 1)'($urandom_range(0, 31)));
      for (int e = 0; e < 40; e++) begin
        int c;
        c = $urandom_range(0, 9);
        if (c < 6) begin
          d = 8'($urandom_range(0, 255));
          if ($urandom_range(0, 1) == 1) d = (m_tb & m_tm) | (d & ~m_tm);
          send_byte(d);
        end else if (c == 6) pulse_detect();
        else if (c == 7) do_read("rnd.read");
        else if (c == 8) do_arm(m_tb, m_tm, (AW + 1)'($urandom_range(0, 31)));
        else @(negedge clk);
      end
      check_status("rnd.end");
      drain("rnd.drain");
      if (m_phase == 1 || m_phase == 2) do_abort();
    end

    // Reset in the middle of a capture
    do_arm(8'h00, 8'h00, 5'd6);
    send_byte(8'h12);
    send_byte(8'h34);
    do_reset();
    check_status("t7.reset");
    chk("t7.rd_data", rd_data, 0);

`ifdef SPI_CAPTURE_TIMEOUT_EN
    begin
      int n;
      do_arm(8'hC3, 8'hFF, 5'd8);
      send_byte(8'hC3);
      send_byte(8'h44);
      n = 1;
      while (!done && n < 300) begin
        @(negedge clk);
        n++;
      end
      chk("t8.cycles", n, 100);
      m_phase = 3; m_tmo = 1;
      check_status("t8.timeout");
      drain("t8.read");
      do_arm(8'h00, 8'h00, 5'd2);
      check_status("t8.rearm");
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_capture_ctrl.md
Name: spi_capture_ctrl

Overview:
- Sequences one SPI byte decoder for the logic analyzer: arm, wait for a trigger byte, capture a programmed number of bytes into a local buffer, then present them for readout.
- Sits between the SPI decoder (dec_* inputs, dec_detect_only output) and the host/readout logic.
- After capture completes, the decoder is switched to detect-only mode, so post-capture frames are counted but not stored.

Parameters:
- DEPTH, 16, capture buffer entries; must be a power of 2, at least 2.
- AW, $clog2(DEPTH), buffer address width.
- TIMEOUT_CYCLES, 65535, idle clk cycles before a timeout fires (TIMEOUT_EN only).

Ports:
- clk  in  1  system clock
- rst  in  1  reset. One clock; reset is asynchronous and active-high.
- arm  in  1  single-cycle pulse: start a capture
- abort  in  1  single-cycle pulse: return to IDLE
- trig_byte  in  8  trigger compare value
- trig_mask  in  8  1 = bit participates in the compare
- capture_len  in  AW+1  bytes to capture, trigger byte included
- dec_data  in  8  decoder byte
- dec_valid  in  1  decoder byte strobe
- dec_detected  in  1  decoder frame-complete strobe
- dec_detect_only  out  1  drives the decoder's detect_only input
- busy  out  1  state is ARMED or CAPTURE
- done  out  1  state is DONE
- timeout  out  1  capture ended by timeout (sticky until arm/abort)
- rd_en  in  1  pop one byte
- rd_data  out  8  buffer byte
- rd_valid  out  1  rd_data valid, one cycle after an accepted rd_en
- rd_empty  out  1  no unread captured bytes
- post_frames  out  8  frames seen in DONE, saturating at 255

Behaviour:
- Reset values:
  - state IDLE
  - dec_detect_only=1
  - busy=0, done=0, timeout=0
  - rd_data=0, rd_valid=0, rd_empty=1
  - post_frames=0
  - internal write pointer, read pointer and count all 0
- Length latch: capture_len is latched on the accepted arm. 0 or >DEPTH is treated as DEPTH.
- IDLE:
  - dec_detect_only=1.
  - arm -> ARMED; clears pointers, post_frames and timeout.
- ARMED:
  - dec_detect_only=0.
  - On dec_valid with ((dec_data ^ trig_byte) & trig_mask)==0: write dec_data at address 0 and go to CAPTURE.
  - If the latched length is 1, go directly to DONE.
  - trig_mask=0 triggers on the first byte.
  - Non-matching bytes are discarded.
- CAPTURE:
  - dec_detect_only=0.
  - Each dec_valid writes the byte at the write pointer and increments it.
  - When the count reaches the latched length, go to DONE on the same edge as the final write.
- DONE:
  - dec_detect_only=1.
  - Each dec_detected increments post_frames, saturating at 255.
  - rd_en is honoured only in DONE and only while rd_empty=0: rd_data=buf[rd_ptr] and rd_valid=1 on the next cycle; rd_ptr increments.
  - rd_en while empty, or in any other state, is ignored (rd_valid stays 0).
  - rd_empty=1 once rd_ptr equals the captured count.
  - arm in DONE -> ARMED, re-initialising as from IDLE.
- Priority: abort > arm > decoder events.
  - abort in any state -> IDLE; buffer contents are kept but rd_empty=1.
  - arm while ARMED or CAPTURE is ignored.
- dec_valid in the same cycle as the DONE transition (final byte) is the last byte stored. Later bytes in DONE are never written.
- Buffer writes use a registered address/data path. Readout latency is 1 cycle.
- Reset asserted mid-capture returns everything to reset values; buffer RAM contents are not cleared.

Optional Feature:
- Macro: SPI_CAPTURE_TIMEOUT_EN.
- Defined:
  - A counter clears on every dec_detected and on entry to CAPTURE, and counts clk cycles while in CAPTURE.
  - On reaching TIMEOUT_CYCLES: go to DONE, set timeout=1, keep the partial byte count (rd_empty reflects it).
- Not defined: timeout is tied 0, no counter is present, and CAPTURE waits indefinitely.

Decomposition:
- Package spi_la_pkg holds:
  - the state encoding localparams (IDLE=2'd0, ARMED=2'd1, CAPTURE=2'd2, DONE=2'd3)
  - the byte width constant (8)
  - the post_frames saturation value
- One sub-module, spi_capture_buf: a DEPTH x 8 simple dual-port register array with a synchronous write port and a registered read port.
- Pointers and the FSM stay in spi_capture_ctrl.

Test Plan:
- arm, trig_byte=8'hA5, trig_mask=8'hFF, capture_len=4; feed 3C, A5, 01, 02, 03 -> 3C discarded; DONE after 03; reading yields A5, 01, 02, 03; rd_empty=1 after the 4th read; rd_en with rd_empty=1 (buffer empty) gives rd_valid=0.
- trig_mask=8'hF0, trig_byte=8'hA0; feed 5A, AF -> trigger on AF; busy=1, done=0 until the length is reached.
- In DONE, pulse dec_detected 300 times -> post_frames=255 and dec_detect_only=1; the next arm clears post_frames to 0.
- abort during CAPTURE after 2 bytes -> IDLE the next cycle, busy=0, rd_empty=1; rd_en produces no rd_valid.
- capture_len=0 with DEPTH=16 -> captures exactly 16 bytes; the 17th dec_valid is not stored and the write pointer stays put.
- SPI_CAPTURE_TIMEOUT_EN with TIMEOUT_CYCLES=100: trigger, 1 more byte, then silence -> at cycle 100 done=1, timeout=1, 2 bytes readable.
